// File: rtl/store_ex_queue_if.sv
// Store execute queue bus: issue packet, branch resolve, ROB commit and D-cache write port.
// Defining STORE_FWD_EN adds the load-forwarding lookup signals.
interface store_ex_queue_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned BMASK_W = 4,
    parameter int unsigned ALU_NUM = 3
);
    localparam int unsigned BN_W  = $clog2(BMASK_W);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                    is_valid;
    logic [XLEN-1:0]         is_base;
    logic [XLEN-1:0]         is_imm;
    logic [XLEN-1:0]         is_data;
    logic [1:0]              is_size;
    logic [BMASK_W-1:0]      is_b_mask;
    logic                    clean_brat_en;
    logic [BN_W-1:0]         clean_brat_num;
    logic [ALU_NUM-1:0]      clean_bit_brat_en;
    logic [ALU_NUM*BN_W-1:0] clean_bit_num_brat_ex;
    logic [1:0]              rob_st_commit;
    logic                    stop_is_st_en;
    logic                    mem_req;
    logic [XLEN-1:0]         mem_addr;
    logic [XLEN-1:0]         mem_data;
    logic [1:0]              mem_size;
    logic                    mem_ack;
    logic [CNT_W-1:0]        sq_count;
`ifdef STORE_FWD_EN
    logic [XLEN-1:0]         ld_addr;
    logic [1:0]              ld_size;
    logic                    fwd_hit;
    logic [XLEN-1:0]         fwd_data;
`endif

    modport master (
        output is_valid, is_base, is_imm, is_data, is_size, is_b_mask,
        output clean_brat_en, clean_brat_num, clean_bit_brat_en, clean_bit_num_brat_ex,
        output rob_st_commit, mem_ack,
        input  stop_is_st_en, mem_req, mem_addr, mem_data, mem_size, sq_count
`ifdef STORE_FWD_EN
        , output ld_addr, ld_size
        , input  fwd_hit, fwd_data
`endif
    );

    modport slave (
        input  is_valid, is_base, is_imm, is_data, is_size, is_b_mask,
        input  clean_brat_en, clean_brat_num, clean_bit_brat_en, clean_bit_num_brat_ex,
        input  rob_st_commit, mem_ack,
        output stop_is_st_en, mem_req, mem_addr, mem_data, mem_size, sq_count
`ifdef STORE_FWD_EN
        , input  ld_addr, ld_size
        , output fwd_hit, fwd_data
`endif
    );
endinterface

// File: rtl/store_ex_queue.sv
// Speculative store queue: computes EA, holds stores until ROB commit, drains in order to the D-cache.
// STORE_FWD_EN enables a combinational youngest-match store-to-load forwarding lookup.
module store_ex_queue #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned BMASK_W = 4,
    parameter int unsigned ALU_NUM = 3
) (
    input  logic              clock,
    input  logic              reset,
    store_ex_queue_if.slave   sq
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned BN_W  = $clog2(BMASK_W);

    typedef enum logic [1:0] {E_EMPTY, E_SPEC, E_COMMITTED} ent_state_e;
    typedef enum logic {S_IDLE, S_REQ} drain_state_e;

    ent_state_e         r_st   [DEPTH];
    logic [XLEN-1:0]    r_addr [DEPTH];
    logic [XLEN-1:0]    r_data [DEPTH];
    logic [1:0]         r_size [DEPTH];
    logic [BMASK_W-1:0] r_mask [DEPTH];
    logic [PTR_W-1:0]   r_head, r_tail, r_count;

    drain_state_e       r_fsm, w_fsm_nxt;
    logic               r_mem_req, w_mem_req_nxt;
    logic [XLEN-1:0]    r_mem_addr, w_mem_addr_nxt;
    logic [XLEN-1:0]    r_mem_data, w_mem_data_nxt;
    logic [1:0]         r_mem_size, w_mem_size_nxt;

    logic [DEPTH-1:0]   w_commit, w_squash;
    logic [PTR_W-1:0]   w_spec_total, w_sq_off, w_tail_sq, w_tail_nxt, w_head_nxt;
    logic               w_sq_found, w_full, w_in_squash, w_enq, w_drain;
    logic [BMASK_W-1:0] w_clr;
    logic [IDX_W-1:0]   w_head_idx, w_next_idx, w_enq_idx;
    logic               w_head_cmt, w_next_cmt;

    assign w_head_idx = r_head[IDX_W-1:0];
    assign w_next_idx = w_head_idx + IDX_W'(1);
    assign w_full     = (r_count == PTR_W'(DEPTH));
    assign w_drain    = (r_fsm == S_REQ) && sq.mem_ack;

    // Oldest SPEC entries in head order take this cycle's commits
    always_comb begin
        logic [IDX_W-1:0] idx;
        logic [1:0]       left;
        w_commit     = '0;
        w_spec_total = '0;
        left         = sq.rob_st_commit;
        for (int k = 0; k < DEPTH; k++) begin
            idx = w_head_idx + IDX_W'(k);
            if (r_st[idx] == E_SPEC) begin
                w_spec_total = w_spec_total + PTR_W'(1);
                if (left != 2'd0) begin
                    w_commit[idx] = 1'b1;
                    left          = left - 2'd1;
                end
            end
        end
    end

    // Squash uses pre-clear masks; the first squashed slot in age order becomes the new tail
    always_comb begin
        logic [IDX_W-1:0] idx;
        w_squash   = '0;
        w_sq_found = 1'b0;
        w_sq_off   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = w_head_idx + IDX_W'(k);
            if (sq.clean_brat_en && (r_st[idx] == E_SPEC) && !w_commit[idx] &&
                r_mask[idx][sq.clean_brat_num]) begin
                w_squash[idx] = 1'b1;
                if (!w_sq_found) begin
                    w_sq_found = 1'b1;
                    w_sq_off   = PTR_W'(k);
                end
            end
        end
    end

    always_comb begin
        w_clr = '0;
        for (int j = 0; j < ALU_NUM; j++) begin
            if (sq.clean_bit_brat_en[j]) w_clr[sq.clean_bit_num_brat_ex[j*BN_W +: BN_W]] = 1'b1;
        end
    end

    assign w_tail_sq   = w_sq_found ? (r_head + w_sq_off) : r_tail;
    assign w_in_squash = sq.clean_brat_en && sq.is_b_mask[sq.clean_brat_num];
    assign w_enq       = sq.is_valid && !w_full && !w_in_squash;
    assign w_enq_idx   = w_tail_sq[IDX_W-1:0];
    assign w_tail_nxt  = w_tail_sq + PTR_W'(w_enq);
    assign w_head_nxt  = r_head + PTR_W'(w_drain);

    // Entry state and pointers; an enqueue may reuse a slot freed by this cycle's squash
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_st[i] <= E_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_drain && (w_head_idx == IDX_W'(i))) r_st[i] <= E_EMPTY;
                else if (w_squash[i])                     r_st[i] <= E_EMPTY;
                else if (w_commit[i])                     r_st[i] <= E_COMMITTED;
                if (w_enq && (w_enq_idx == IDX_W'(i)))    r_st[i] <= E_SPEC;
            end
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= w_tail_nxt - w_head_nxt;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_enq && (w_enq_idx == IDX_W'(i))) begin
                r_addr[i] <= sq.is_base + sq.is_imm;
                r_data[i] <= sq.is_data;
                r_size[i] <= sq.is_size;
                r_mask[i] <= sq.is_b_mask & ~w_clr;
            end else begin
                r_mask[i] <= r_mask[i] & ~w_clr;
            end
        end
    end

    // Commits landing this cycle count, so mem_req rises the cycle after rob_st_commit
    assign w_head_cmt = (r_st[w_head_idx] == E_COMMITTED) || w_commit[w_head_idx];
    assign w_next_cmt = (r_st[w_next_idx] == E_COMMITTED) || w_commit[w_next_idx];

    always_comb begin
        w_fsm_nxt      = r_fsm;
        w_mem_req_nxt  = r_mem_req;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_data_nxt = r_mem_data;
        w_mem_size_nxt = r_mem_size;
        case (r_fsm)
            S_IDLE: begin
                if (w_head_cmt) begin
                    w_fsm_nxt      = S_REQ;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_addr_nxt = r_addr[w_head_idx];
                    w_mem_data_nxt = r_data[w_head_idx];
                    w_mem_size_nxt = r_size[w_head_idx];
                end
            end
            S_REQ: begin
                if (sq.mem_ack) begin
                    if (w_next_cmt) begin
                        w_mem_addr_nxt = r_addr[w_next_idx];
                        w_mem_data_nxt = r_data[w_next_idx];
                        w_mem_size_nxt = r_size[w_next_idx];
                    end else begin
                        w_fsm_nxt     = S_IDLE;
                        w_mem_req_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_fsm_nxt     = S_IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fsm      <= S_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_mem_size <= '0;
        end else begin
            r_fsm      <= w_fsm_nxt;
            r_mem_req  <= w_mem_req_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_mem_data <= w_mem_data_nxt;
            r_mem_size <= w_mem_size_nxt;
        end
    end

    assign sq.stop_is_st_en = w_full;
    assign sq.sq_count      = r_count;
    assign sq.mem_req       = r_mem_req;
    assign sq.mem_addr      = r_mem_addr;
    assign sq.mem_data      = r_mem_data;
    assign sq.mem_size      = r_mem_size;

`ifdef STORE_FWD_EN
    // Scan oldest to youngest so the youngest matching store wins
    always_comb begin
        logic [IDX_W-1:0] idx;
        sq.fwd_hit  = 1'b0;
        sq.fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = w_head_idx + IDX_W'(k);
            if ((r_st[idx] != E_EMPTY) && (r_addr[idx][XLEN-1:2] == sq.ld_addr[XLEN-1:2]) &&
                (r_size[idx] == sq.ld_size)) begin
                sq.fwd_hit = 1'b1;
                case (r_size[idx])
                    2'd0:    sq.fwd_data = XLEN'(r_data[idx][7:0]);
                    2'd1:    sq.fwd_data = XLEN'(r_data[idx][15:0]);
                    default: sq.fwd_data = r_data[idx];
                endcase
            end
        end
    end
`endif

    a_no_enq_when_full: assert property (@(posedge clock) disable iff (reset)
        !(sq.is_valid && w_full));
    a_commit_le_spec: assert property (@(posedge clock) disable iff (reset)
        PTR_W'(sq.rob_st_commit) <= w_spec_total);
endmodule

// File: tb/tb_store_ex_queue.sv
// Scoreboard bench for store_ex_queue: model queue of stores, popped and compared on each D-cache handshake.
module tb_store_ex_queue;
    localparam int unsigned DEPTH = 8;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic [3:0]  mask;
        bit          cmt;
    } ment_t;

    logic  clock;
    logic  reset;
    ment_t mq[$];
    int    n_checks;
    int    n_errors;

    store_ex_queue_if #(.XLEN(32), .DEPTH(DEPTH), .BMASK_W(4), .ALU_NUM(3)) bus ();

    store_ex_queue #(.XLEN(32), .DEPTH(DEPTH), .BMASK_W(4), .ALU_NUM(3)) dut (
        .clock (clock),
        .reset (reset),
        .sq    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int spec_cnt();
        int s = 0;
        foreach (mq[i]) if (!mq[i].cmt) s++;
        return s;
    endfunction

    task automatic chk_count();
        check_val("sq_count", 64'(bus.sq_count), 64'(mq.size()));
    endtask

    task automatic set_issue(input logic [31:0] b, input logic [31:0] im, input logic [31:0] d,
                             input logic [1:0] s, input logic [3:0] m);
        bus.is_valid  = 1'b1;
        bus.is_base   = b;
        bus.is_imm    = im;
        bus.is_data   = d;
        bus.is_size   = s;
        bus.is_b_mask = m;
    endtask

    // Apply currently driven inputs to the model, then clock them into the DUT
    task automatic step();
        int          c;
        int          sz0;
        logic [3:0]  clr;
        ment_t       e;
        sz0 = mq.size();
        c   = int'(bus.rob_st_commit);
        for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].cmt && c > 0) begin
                e = mq[i]; e.cmt = 1'b1; mq[i] = e; c--;
            end
        end
        if (bus.clean_brat_en) begin
            while (mq.size() > 0 && !mq[mq.size()-1].cmt && mq[mq.size()-1].mask[bus.clean_brat_num])
                void'(mq.pop_back());
        end
        clr = '0;
        for (int j = 0; j < 3; j++)
            if (bus.clean_bit_brat_en[j]) clr[bus.clean_bit_num_brat_ex[j*2 +: 2]] = 1'b1;
        for (int i = 0; i < mq.size(); i++) begin
            e = mq[i]; e.mask = e.mask & ~clr; mq[i] = e;
        end
        if (bus.is_valid && sz0 < DEPTH && !(bus.clean_brat_en && bus.is_b_mask[bus.clean_brat_num])) begin
            e.addr = bus.is_base + bus.is_imm;
            e.data = bus.is_data;
            e.size = bus.is_size;
            e.mask = bus.is_b_mask & ~clr;
            e.cmt  = 1'b0;
            mq.push_back(e);
        end
        @(posedge clock);
        #1;
        bus.is_valid          = 1'b0;
        bus.rob_st_commit     = 2'd0;
        bus.clean_brat_en     = 1'b0;
        bus.clean_bit_brat_en = 3'b000;
    endtask

    task automatic drain_all();
        int n = 0;
        int s;
        bus.mem_ack = 1'b1;
        while (mq.size() > 0 && n < 100) begin
            s = spec_cnt();
            bus.rob_st_commit = 2'((s > 2) ? 2 : s);
            step();
            n++;
        end
        check_val("drain_left", 64'(mq.size()), 64'd0);
        chk_count();
        check_val("drain_req_low", 64'(bus.mem_req), 64'd0);
    endtask

    // Each completed handshake must match the oldest modelled store
    always @(negedge clock) begin
        ment_t e;
        if (!reset && bus.mem_req && bus.mem_ack) begin
            if (mq.size() == 0) begin
                check_val("drain_unexpected", 64'(bus.mem_req), 64'd0);
            end else begin
                e = mq.pop_front();
                check_val("drain_committed", 64'(bus.mem_req), 64'(e.cmt));
                check_val("drain_addr", 64'(bus.mem_addr), 64'(e.addr));
                check_val("drain_data", 64'(bus.mem_data), 64'(e.data));
                check_val("drain_size", 64'(bus.mem_size), 64'(e.size));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ment_t       a;
        int          s;
        int          r;
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus.is_valid = 1'b0; bus.is_base = '0; bus.is_imm = '0; bus.is_data = '0;
        bus.is_size = '0; bus.is_b_mask = '0; bus.clean_brat_en = 1'b0; bus.clean_brat_num = '0;
        bus.clean_bit_brat_en = '0; bus.clean_bit_num_brat_ex = '0; bus.rob_st_commit = '0;
        bus.mem_ack = 1'b0;
`ifdef STORE_FWD_EN
        bus.ld_addr = '0; bus.ld_size = '0;
`endif
        repeat (3) @(posedge clock);
        #1;
        check_val("rst_stop", 64'(bus.stop_is_st_en), 64'd0);
        check_val("rst_req", 64'(bus.mem_req), 64'd0);
        check_val("rst_addr", 64'(bus.mem_addr), 64'd0);
        check_val("rst_data", 64'(bus.mem_data), 64'd0);
        check_val("rst_size", 64'(bus.mem_size), 64'd0);
        check_val("rst_count", 64'(bus.sq_count), 64'd0);
        reset = 1'b0;

        // Single store, commit, drain with ack tied high
        bus.mem_ack = 1'b1;
        set_issue(32'h100, 32'h8, 32'hDEAD, 2'd2, 4'h0);
        step();
        chk_count();
        check_val("t1_req_before_commit", 64'(bus.mem_req), 64'd0);
        bus.rob_st_commit = 2'd1;
        step();
        check_val("t1_req", 64'(bus.mem_req), 64'd1);
        check_val("t1_addr", 64'(bus.mem_addr), 64'h108);
        check_val("t1_data", 64'(bus.mem_data), 64'hDEAD);
        step();
        chk_count();
        check_val("t1_req_done", 64'(bus.mem_req), 64'd0);

        // Fill to full, then commit two with ack high
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_issue(32'h1000 + 32'(i * 16), 32'h4, 32'h100 + 32'(i), 2'd2, 4'h0);
            step();
            if (i == 6) check_val("t2_stop_at7", 64'(bus.stop_is_st_en), 64'd0);
        end
        chk_count();
        check_val("t2_stop_full", 64'(bus.stop_is_st_en), 64'd1);
        bus.mem_ack = 1'b1;
        bus.rob_st_commit = 2'd2;
        step();
        check_val("t2_stop_while_drain", 64'(bus.stop_is_st_en), 64'd1);
        check_val("t2_req", 64'(bus.mem_req), 64'd1);
        step();
        check_val("t2_stop_released", 64'(bus.stop_is_st_en), 64'd0);
        chk_count();
        drain_all();

        // Squash a contiguous run of younger stores
        bus.mem_ack = 1'b0;
        set_issue(32'h2000, 32'h0, 32'hA0, 2'd2, 4'b0000); step();
        set_issue(32'h2004, 32'h0, 32'hA1, 2'd2, 4'b0001); step();
        set_issue(32'h2008, 32'h0, 32'hA2, 2'd2, 4'b0001); step();
        set_issue(32'h200C, 32'h0, 32'hA3, 2'd2, 4'b0011); step();
        bus.clean_brat_en = 1'b1; bus.clean_brat_num = 2'd0;
        step();
        chk_count();
        check_val("t3_count_one", 64'(bus.sq_count), 64'd1);
        set_issue(32'h2100, 32'h0, 32'hA4, 2'd1, 4'b0000);
        step();
        chk_count();
        drain_all();

        // Clean-bit before squash, same-cycle clean on incoming, squashed incoming, committed survives
        bus.mem_ack = 1'b0;
        set_issue(32'h3000, 32'h10, 32'hB0, 2'd2, 4'b0011); step();
        bus.clean_bit_brat_en = 3'b001; bus.clean_bit_num_brat_ex = 6'b000001;
        step();
        bus.clean_brat_en = 1'b1; bus.clean_brat_num = 2'd1;
        step();
        chk_count();
        set_issue(32'h3100, 32'h0, 32'hB1, 2'd0, 4'b0011);
        bus.clean_bit_brat_en = 3'b100; bus.clean_bit_num_brat_ex = 6'b010000;
        step();
        bus.clean_brat_en = 1'b1; bus.clean_brat_num = 2'd1;
        step();
        chk_count();
        check_val("t4_both_survive", 64'(bus.sq_count), 64'd2);
        set_issue(32'h3200, 32'h0, 32'hB2, 2'd2, 4'b0100);
        bus.clean_brat_en = 1'b1; bus.clean_brat_num = 2'd2;
        step();
        check_val("t4_incoming_dropped", 64'(bus.sq_count), 64'd2);
        bus.rob_st_commit = 2'd1;
        step();
        bus.clean_brat_en = 1'b1; bus.clean_brat_num = 2'd0;
        step();
        chk_count();
        check_val("t4_committed_kept", 64'(bus.sq_count), 64'd1);

        // mem_* hold steady while ack is withheld
        a = mq[0];
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("t5_req_hold", 64'(bus.mem_req), 64'd1);
            check_val("t5_addr_hold", 64'(bus.mem_addr), 64'(a.addr));
            check_val("t5_data_hold", 64'(bus.mem_data), 64'(a.data));
        end
        drain_all();

`ifdef STORE_FWD_EN
        bus.mem_ack = 1'b0;
        set_issue(32'h1F0, 32'h10, 32'h1234, 2'd2, 4'h0); step();
        set_issue(32'h200, 32'h0, 32'h5678, 2'd2, 4'h0); step();
        bus.ld_addr = 32'h200; bus.ld_size = 2'd2;
        #1;
        check_val("fwd_hit", 64'(bus.fwd_hit), 64'd1);
        check_val("fwd_data", 64'(bus.fwd_data), 64'h5678);
        bus.ld_size = 2'd0;
        #1;
        check_val("fwd_size_miss", 64'(bus.fwd_hit), 64'd0);
        drain_all();
`endif

        // Random issue/commit/ack traffic exercising pointer wrap and back-to-back drains
        for (int cyc = 0; cyc < 300; cyc++) begin
            bus.mem_ack = 1'($urandom_range(0, 1));
            if (mq.size() < DEPTH && $urandom_range(0, 2) != 0)
                set_issue($urandom, $urandom, $urandom, 2'($urandom_range(0, 2)), 4'h0);
            s = spec_cnt();
            r = $urandom_range(0, 2);
            if (r > s) r = s;
            bus.rob_st_commit = 2'(r);
            step();
            chk_count();
            check_val("rnd_stop", 64'(bus.stop_is_st_en), 64'(mq.size() == DEPTH));
        end
        drain_all();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
